// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a fixed-latency single-port memory.
// One transaction in flight; fetch and data alternate when both are pending.
module mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              if_gnt,
   output logic              d_gnt,
   output logic              if_done,
   output logic              d_done,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t     state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic       last_d;    // data was granted most recently
   logic       owner_d;   // current transaction belongs to the data port
   logic       owner_we;

   logic arb, any_req, pick_if, pick_d, done_fire;

   assign arb       = (state == IDLE) || (state == DONE);
   assign any_req   = if_req || d_req;
   assign pick_if   = if_req && (!d_req || last_d);
   assign pick_d    = d_req && !pick_if;
   assign done_fire = (state == WAIT) && (cnt == 3'd1);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE, DONE: state_nxt = any_req ? ISSUE : IDLE;
         ISSUE: begin
            state_nxt = WAIT;
            cnt_nxt   = 3'(MEM_LAT);
         end
         WAIT: begin
            cnt_nxt = cnt - 3'd1;
            if (cnt == 3'd1) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are loaded on the edge entering ISSUE/DONE so they are visible in that state.
   always_ff @(posedge clock) begin
      if (reset) begin
         if_gnt    <= 1'b0;
         d_gnt     <= 1'b0;
         if_done   <= 1'b0;
         d_done    <= 1'b0;
         rdata     <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         last_d    <= 1'b1;
         owner_d   <= 1'b0;
         owner_we  <= 1'b0;
      end else begin
         if_gnt  <= arb && pick_if;
         d_gnt   <= arb && pick_d;
         mem_en  <= arb && any_req;
         mem_we  <= arb && pick_d && d_we;
         if_done <= done_fire && !owner_d;
         d_done  <= done_fire && owner_d;
         if (arb && any_req) begin
            mem_addr <= pick_d ? d_addr : if_addr;
            owner_d  <= pick_d;
            owner_we <= pick_d && d_we;
            last_d   <= pick_d;
            if (pick_d && d_we) mem_wdata <= d_wdata;
         end
         if (done_fire && !owner_we) rdata <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter at MEM_LAT = 2, 1 and 7 side by side.
module tb_mem_arbiter;
   logic clock = 1'b0;
   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   bit fin [3];

   typedef struct {
      int          cyc;
      bit          is_d;
      bit          we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
   } txn_t;

   function automatic logic [15:0] mem_val(input logic [15:0] a);
      if (a == 16'h0010) return 16'hBEEF;
      return (a * 16'd37) ^ 16'h5A5A;
   endfunction

   task automatic check(input int lat, input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (MEM_LAT=%0d) at %0t: got %h expected %h", name, lat, $time, act, exp);
      end
   endtask

   for (genvar k = 0; k < 3; k++) begin : g_lat
      localparam int LAT = (k == 0) ? 2 : (k == 1) ? 1 : 7;

      logic        reset, if_req, d_req, d_we;
      logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
      logic        if_gnt, d_gnt, if_done, d_done, mem_en, mem_we;
      logic [15:0] rdata, mem_addr, mem_wdata;

      mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
         .clock(clock), .reset(reset),
         .if_req(if_req), .if_addr(if_addr),
         .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
         .if_gnt(if_gnt), .d_gnt(d_gnt), .if_done(if_done), .d_done(d_done),
         .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
         .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
      );

      int   cyc = 0;
      int   free_cyc = 0;
      bit   last_d = 1'b1;
      bit   armed = 1'b0;
      txn_t gq[$];
      txn_t dq[$];

      // Memory stub: read data appears exactly LAT cycles after the command, junk otherwise.
      bit          pv [8];
      logic [15:0] pa [8];
      initial begin
         for (int i = 0; i < 8; i++) begin pv[i] = 1'b0; pa[i] = '0; end
         mem_rdata = 16'h0;
         forever begin
            @(posedge clock); #1;
            for (int i = 7; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
            pv[0] = (mem_en === 1'b1) && (mem_we === 1'b0);
            pa[0] = mem_addr;
            mem_rdata = pv[LAT] ? mem_val(pa[LAT]) : 16'($urandom);
         end
      end

      // Reference model: transaction-level, in cycle numbers.
      initial begin
         txn_t t;
         bit   pd;
         forever begin
            @(posedge clock);
            if (reset) begin
               gq.delete(); dq.delete();
               free_cyc = cyc + 1;
               last_d   = 1'b1;
               armed    = 1'b1;
            end else if (armed && cyc >= free_cyc && (if_req || d_req)) begin
               pd      = d_req && !(if_req && last_d);
               t.cyc   = cyc + 1;
               t.is_d  = pd;
               t.we    = pd && d_we;
               t.addr  = pd ? d_addr : if_addr;
               t.wdata = pd ? d_wdata : 16'h0;
               t.rdata = mem_val(t.addr);
               gq.push_back(t);
               t.cyc = cyc + LAT + 2;
               dq.push_back(t);
               free_cyc = cyc + LAT + 2;
               last_d   = pd;
            end
            cyc++;
         end
      end

      // Monitor
      initial begin
         txn_t        t;
         bit          eg, ed;
         logic [15:0] rdata_exp;
         rdata_exp = 16'h0;
         forever begin
            @(negedge clock);
            if (armed) begin
               eg = (gq.size() > 0) && (gq[0].cyc == cyc);
               ed = (dq.size() > 0) && (dq[0].cyc == cyc);
               if (eg) begin
                  t = gq.pop_front();
                  check(LAT, "gnt/mem_en", {29'd0, if_gnt, d_gnt, mem_en}, {29'd0, !t.is_d, t.is_d, 1'b1});
                  check(LAT, "mem_addr", {16'd0, mem_addr}, {16'd0, t.addr});
                  check(LAT, "mem_we", {31'd0, mem_we}, {31'd0, t.we});
                  if (t.we) check(LAT, "mem_wdata", {16'd0, mem_wdata}, {16'd0, t.wdata});
               end else begin
                  check(LAT, "idle gnt/mem_en", {29'd0, if_gnt, d_gnt, mem_en}, 32'd0);
               end
               if (ed) begin
                  t = dq.pop_front();
                  check(LAT, "done", {30'd0, if_done, d_done}, {30'd0, !t.is_d, t.is_d});
                  if (!t.we) rdata_exp = t.rdata;
               end else begin
                  check(LAT, "idle done", {30'd0, if_done, d_done}, 32'd0);
               end
               check(LAT, "rdata", {16'd0, rdata}, {16'd0, rdata_exp});
               if (reset) rdata_exp = 16'h0;
            end
         end
      end

      task automatic step(input int n);
         repeat (n) begin @(posedge clock); #1; end
      endtask

      task automatic wait_gnt(input bit want_d);
         int n;
         n = 0;
         while (!(want_d ? d_gnt : if_gnt) && n < 20) begin step(1); n++; end
         if (n >= 20) check(LAT, "gnt timeout", 32'd0, 32'd1);
      endtask

      // Stimulus
      initial begin
         reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
         if_addr = '0; d_addr = '0; d_wdata = '0;
         step(3);
         // Both held from reset release: fetch, data, fetch...
         reset = 1'b0;
         if_req = 1'b1; if_addr = 16'h0100;
         d_req  = 1'b1; d_addr  = 16'h0200; d_we = 1'b0;
         step(3 * (LAT + 2) + 1);
         if_req = 1'b0; d_req = 1'b0;
         step(LAT + 3);
         // Lone fetch read at 0x0010
         if_req = 1'b1; if_addr = 16'h0010;
         wait_gnt(1'b0); if_req = 1'b0;
         step(LAT + 3);
         // Data write; rdata must keep the previous read value
         d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
         wait_gnt(1'b1); d_req = 1'b0; d_we = 1'b0;
         step(LAT + 3);
         // Reset one cycle after the grant of a read aborts it
         if_req = 1'b1; if_addr = 16'h0020;
         wait_gnt(1'b0); if_req = 1'b0;
         reset = 1'b1; step(1);
         reset = 1'b0; step(LAT + 4);
         // Random traffic with occasional drops and resets
         for (int c = 0; c < 400; c++) begin
            if (if_gnt) if_req = 1'b0;
            else if (if_req && $urandom_range(15) == 0) if_req = 1'b0;
            else if (!if_req && $urandom_range(3) == 0) begin
               if_req = 1'b1; if_addr = 16'($urandom);
            end
            if (d_gnt) d_req = 1'b0;
            else if (d_req && $urandom_range(15) == 0) d_req = 1'b0;
            else if (!d_req && $urandom_range(3) == 0) begin
               d_req = 1'b1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
            end
            if (reset) reset = 1'b0;
            else if ($urandom_range(59) == 0) reset = 1'b1;
            step(1);
         end
         reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
         step(LAT + 5);
         check(LAT, "drain", 32'(gq.size() + dq.size()), 32'd0);
         fin[k] = 1'b1;
      end
   end

   initial begin
      int n;
      n = 0;
      while (!(fin[0] && fin[1] && fin[2]) && n < 20000) begin @(posedge clock); n++; end
      if (n >= 20000) begin
         tests++; fails++;
         $display("FAIL run timeout: got unfinished expected finished");
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
